// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported memory: port A (CPU data side) and
// port B (loader/debug) with round-robin ties, a bounded A lock and registered reads.
module mem_arbiter #(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_be,
  input  logic        a_lock,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_be,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_stall,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rd
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_TOP = CW'(LOCK_MAX);

  // Round-robin pointer: which port won the most recent grant.
  localparam logic [0:0] LAST_A = 1'b0;
  localparam logic [0:0] LAST_B = 1'b1;

  logic [0:0]    last_gnt;
  logic [CW-1:0] lock_cnt;
  logic          force_b;
  logic          lock_hold;

  // B is owed one grant once A has used up its locked budget.
  assign force_b   = b_req && (lock_cnt == LOCK_TOP);
  assign lock_hold = a_req && a_lock && (lock_cnt != '0);

  always_comb begin
    // NOTE: both grants get a default before any branch so no path leaves them unassigned (no latch).
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (force_b) begin
      b_gnt = 1'b1;
    end else if (lock_hold) begin
      a_gnt = 1'b1;
    end else if (a_req && b_req) begin
      if (last_gnt == LAST_B) a_gnt = 1'b1;
      else                    b_gnt = 1'b1;
    end else if (a_req) begin
      a_gnt = 1'b1;
    end else if (b_req) begin
      b_gnt = 1'b1;
    end
  end

  assign a_stall = a_req & ~a_gnt;

  // Idle memory command is all zeros so an unused cycle cannot look like a write.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    mem_be = '0;
    if (a_gnt) begin
      mem_we = a_we;
      mem_a  = a_addr;
      mem_wd = a_wdata;
      mem_be = a_be;
    end else if (b_gnt) begin
      mem_we = b_we;
      mem_a  = b_addr;
      mem_wd = b_wdata;
      mem_be = b_be;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= LAST_B;
      lock_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
      if (a_gnt)      last_gnt <= LAST_A;
      else if (b_gnt) last_gnt <= LAST_B;

      if (b_gnt || !a_req || !a_lock)          lock_cnt <= '0;
      else if (a_gnt && (lock_cnt != LOCK_TOP)) lock_cnt <= lock_cnt + CW'(1);
    end
  end

  // Read data is captured on the granting edge; rdata holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= mem_rd;
      if (b_gnt && !b_we) b_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic, all checked
// against a rule-level model of grants, lock budget, memory command and read data.
module tb_mem_arbiter;

  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_be, b_be;
  logic        a_gnt, b_gnt, a_stall, a_rvalid, b_rvalid, mem_we;
  logic [31:0] a_rdata, b_rdata, mem_a, mem_wd, mem_rd;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          m_lock;
  bit          m_last_a;
  logic        m_a_rv, m_b_rv;
  logic [31:0] m_a_rd, m_b_rd;

  mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_lock(a_lock),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_stall(a_stall),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_be(mem_be), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Bench-side memory contents, a fixed function of the address
  function automatic logic [31:0] mem_fn(input logic [31:0] addr);
    if (addr == 32'h40) return 32'h1234_5678;
    return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  always_comb mem_rd = mem_fn(mem_a);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_lock   = 0;
    m_last_a = 1'b0;
    m_a_rv   = 1'b0;
    m_b_rv   = 1'b0;
    m_a_rd   = '0;
    m_b_rd   = '0;
  endtask

  // 0 = none, 1 = A, 2 = B
  function automatic logic [1:0] model_grant();
    if (m_lock == LOCK_MAX && b_req)         return 2'd2;
    if (a_req && a_lock && m_lock > 0)       return 2'd1;
    if (a_req && b_req)                      return m_last_a ? 2'd2 : 2'd1;
    if (a_req)                               return 2'd1;
    if (b_req)                               return 2'd2;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
  endtask

  // One arbitration cycle; called just after a falling edge with inputs set.
  // dir_g = 3 means no directed grant expectation for this cycle.
  task automatic step(input logic [1:0] dir_g);
    logic [1:0] g;
    #1;
    g = model_grant();
    if (dir_g != 2'd3) check("dir_gnt", 32'({b_gnt, a_gnt}), 32'(dir_g));
    check("gnt", 32'({b_gnt, a_gnt}), 32'(g));
    check("a_stall", 32'(a_stall), 32'(a_req && g != 2'd1));
    check("mem_we", 32'(mem_we), 32'(g == 2'd1 ? a_we : g == 2'd2 ? b_we : 1'b0));
    check("mem_a", mem_a, g == 2'd1 ? a_addr : g == 2'd2 ? b_addr : 32'h0);
    check("mem_wd", mem_wd, g == 2'd1 ? a_wdata : g == 2'd2 ? b_wdata : 32'h0);
    check("mem_be", 32'(mem_be), 32'(g == 2'd1 ? a_be : g == 2'd2 ? b_be : 4'h0));
    @(posedge clk);
    m_a_rv = (g == 2'd1) && !a_we;
    m_b_rv = (g == 2'd2) && !b_we;
    if (m_a_rv) m_a_rd = mem_fn(a_addr);
    if (m_b_rv) m_b_rd = mem_fn(b_addr);
    if (g == 2'd1) m_last_a = 1'b1;
    if (g == 2'd2) m_last_a = 1'b0;
    if (g == 2'd2 || !a_req || !a_lock)       m_lock = 0;
    else if (g == 2'd1 && m_lock < LOCK_MAX)  m_lock++;
    #1;
    check("a_rvalid", 32'(a_rvalid), 32'(m_a_rv));
    check("b_rvalid", 32'(b_rvalid), 32'(m_b_rv));
    check("a_rdata", a_rdata, m_a_rd);
    check("b_rdata", b_rdata, m_b_rd);
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    m_reset();
    #1;
    check("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    check("rst_b_rvalid", 32'(b_rvalid), 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_b_rdata", b_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Both reading after reset: A,B,A,B with alternating addresses
    a_req = 1; a_addr = 32'h0000_1000; b_req = 1; b_addr = 32'h0000_2000;
    step(2'd1); step(2'd2); step(2'd1); step(2'd2);

    // Locked A against a persistent B: A,A,A,A,B,A (stall on the B cycle)
    a_lock = 1; a_addr = 32'h0000_3000;
    step(2'd1); step(2'd1); step(2'd1); step(2'd1);
    step(2'd2);
    step(2'd1);
    clear_inputs();

    // Idle cycle
    step(2'd0);

    // A-only read at 0x40
    a_req = 1; a_addr = 32'h40;
    step(2'd1);
    check("a_read_valid", 32'(a_rvalid), 32'h1);
    check("a_read_data", a_rdata, 32'h1234_5678);
    clear_inputs();

    // B write: memory command mirrors B, no read valid
    b_req = 1; b_we = 1; b_addr = 32'h80; b_wdata = 32'hDEAD_BEEF; b_be = 4'b0011;
    step(2'd2);
    check("b_write_rvalid", 32'(b_rvalid), 32'h0);
    clear_inputs();

    // Reset pulsed mid-cycle after an A read has been captured
    a_req = 1; a_addr = 32'h0000_0500;
    step(2'd1);
    #2 reset = 1'b1;
    m_reset();
    #1;
    check("midrst_a_rvalid", 32'(a_rvalid), 32'h0);
    check("midrst_a_rdata", a_rdata, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_hold_rvalid", 32'(a_rvalid), 32'h0);
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_rvalid", 32'(a_rvalid), 32'h0);
    @(negedge clk);
    a_req = 1; a_addr = 32'h0000_0600; b_req = 1; b_addr = 32'h0000_0700;
    step(2'd1);
    clear_inputs();

    // Randomized traffic, lock asserted often to exercise the budget
    for (int i = 0; i < 400; i++) begin
      a_req   = ($urandom_range(0, 3) != 0);
      b_req   = ($urandom_range(0, 2) != 0);
      a_lock  = ($urandom_range(0, 3) != 0);
      a_we    = $urandom_range(0, 1) == 1;
      b_we    = $urandom_range(0, 1) == 1;
      a_addr  = $urandom;
      b_addr  = $urandom;
      a_wdata = $urandom;
      b_wdata = $urandom;
      a_be    = 4'($urandom);
      b_be    = 4'($urandom);
      step(2'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 4, max consecutive locked grants to port A before port B is forced one grant.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_req, b_req  input  1 each  access request from port A (CPU data side) / port B (loader/debug).
REQ-005 a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-006 a_addr, b_addr  input  32 each  byte address.
REQ-007 a_wdata, b_wdata  input  32 each  write data.
REQ-008 a_be, b_be  input  4 each  byte enables for writes.
REQ-009 a_lock  input  1  port A requests held ownership (read-modify-write).
REQ-010 a_gnt, b_gnt  output  1 each  access accepted this cycle.
REQ-011 a_stall  output  1  a_req & ~a_gnt.
REQ-012 a_rdata, b_rdata  output  32 each  registered read data.
REQ-013 a_rvalid, b_rvalid  output  1 each  read data valid pulse.
REQ-014 mem_we  output  1; mem_a  output  32; mem_wd  output  32; mem_be  output  4  memory command.
REQ-015 mem_rd  input  32  combinational memory read data for mem_a.

Function
REQ-016 Grants SHALL be combinational from current inputs and state; at most one of a_gnt/b_gnt high per cycle; one access per granted cycle.
REQ-017 Only one requester active -> that requester SHALL be granted (subject to REQ-020).
REQ-018 Both active, no lock -> round-robin: grant the port not granted most recently; pointer last_gnt updates on every grant.
REQ-019 Lock: while lock_cnt > 0 and a_lock=1 and a_req=1, A SHALL be granted regardless of b_req; lock_cnt increments on each such A grant with a_lock=1, starts counting at first locked A grant.
REQ-020 When lock_cnt = LOCK_MAX and b_req=1, B SHALL be granted that cycle, lock_cnt cleared; A resumes per REQ-018/019 afterward.
REQ-021 lock_cnt SHALL clear whenever a_lock=0, a_req=0, or B is granted; saturates at LOCK_MAX when b_req=0.
REQ-022 Memory mux: granted port's we/addr/wdata/be drive mem_*; mem_we = granted we; no grant -> mem_we=0, mem_a=0, mem_wd=0, mem_be=0.
REQ-023 Granted read: mem_rd captured at that clock edge into x_rdata; x_rvalid high exactly the following cycle (latency 1), else 0.
REQ-024 x_rdata SHALL hold its last value when x_rvalid=0; writes never assert rvalid.
REQ-025 Requesters SHALL hold req/we/addr/wdata/be stable until granted; arbiter needs no queue.
REQ-026 Address bits pass unmodified; no alignment checks.
REQ-027 Back-to-back grants to the same port on consecutive cycles SHALL be supported with a rvalid each cycle for reads.

Reset
REQ-028 Reset asserted: a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, lock_cnt=0, last_gnt=B (first tie goes to A), immediately without clock.
REQ-029 Reset mid-read: captured data discarded, no rvalid after release; first cycle after release arbitrates as from reset.

Verification
REQ-030 a_req only, read addr 0x40, mem_rd=0x12345678 -> a_gnt same cycle, a_rvalid=1 and a_rdata=0x12345678 next cycle.
REQ-031 Both req after reset, held 4 cycles, no lock -> grant sequence A,B,A,B; mem_a alternates between a_addr and b_addr.
REQ-032 a_lock=1, a_req and b_req held high, LOCK_MAX=4 -> A,A,A,A,B,A; lock_cnt cleared on B grant.
REQ-033 b_req write addr 0x80, wdata 0xDEADBEEF, be 0b0011 -> mem_we=1, mem_a=0x80, mem_wd=0xDEADBEEF, mem_be=0b0011, b_rvalid stays 0.
REQ-034 No requests -> mem_we=0, a_stall=0; a_req while B locked-out case of REQ-032 -> a_stall=1 on B cycle.
REQ-035 Reset pulsed mid-cycle after A read grant -> a_rvalid=0 immediately and next cycle; next tie grants A.
